// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM state encoding,
// supported RAM read latency and the access legality check.
package lsu_pkg;

  localparam int RAM_LAT = 1;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_RWAIT = 3'd2,
    ST_WR    = 3'd3,
    ST_ERR   = 3'd4,
    ST_DONE  = 3'd5
  } lsu_state_e;

  // Unsigned variants exist only for loads; alignment follows access width.
  function automatic logic access_legal(input logic       we,
                                        input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    case (funct3)
      F3_B:    ok = 1'b1;
      F3_BU:   ok = !we;
      F3_H:    ok = !addr_lo[0];
      F3_HU:   ok = !we && !addr_lo[0];
      F3_W:    ok = (addr_lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic is_word_store(input logic we, input logic [2:0] funct3);
    return we && (funct3 == F3_W);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: load extraction with sign/zero extension
// and sub-word store merge into an existing RAM word (little-endian lanes).
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] rd_word_i,
  input  logic [31:0] old_word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] ld_data_o,
  output logic [31:0] st_word_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte = rd_word_i[7:0];
    case (addr_lo_i)
      2'd0:    ld_byte = rd_word_i[7:0];
      2'd1:    ld_byte = rd_word_i[15:8];
      2'd2:    ld_byte = rd_word_i[23:16];
      default: ld_byte = rd_word_i[31:24];
    endcase
    ld_half = addr_lo_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];
  end

  always_comb begin
    ld_data_o = rd_word_i;
    case (funct3_i)
      F3_B:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data_o = {24'h0, ld_byte};
      F3_H:    ld_data_o = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data_o = {16'h0, ld_half};
      default: ld_data_o = rd_word_i;
    endcase
  end

  // Each lane decides independently whether the store covers it; uncovered
  // lanes keep the bytes returned by the read half of the RMW.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic       hit;
    logic [7:0] src;

    always_comb begin
      hit = 1'b1;
      src = wdata_i[8*gi +: 8];
      case (funct3_i[1:0])
        2'b00: begin
          hit = (addr_lo_i == 2'(gi));
          src = wdata_i[7:0];
        end
        2'b01: begin
          hit = (addr_lo_i[1] == 1'(gi / 2));
          src = wdata_i[8*(gi % 2) +: 8];
        end
        default: begin
          hit = 1'b1;
          src = wdata_i[8*gi +: 8];
        end
      endcase
    end

    assign st_word_o[8*gi +: 8] = hit ? src : old_word_i[8*gi +: 8];
  end

endmodule

// File: rtl/lsu_ram_port.sv
// RV32I load/store port onto a word-write RAM with 1-cycle registered read.
// Sub-word stores are read-modify-write; busy/done lets the core stall its PC.
module lsu_ram_port
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int RAM_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [31:0]       rdata_o,
  output logic [ADDR_W-3:0] ram_addr_o,
  output logic [31:0]       ram_wdata_o,
  output logic              ram_rden_o,
  output logic              ram_wren_o,
  input  logic [31:0]       ram_q_i
);

  // Any latency other than one cycle cannot be sequenced here, so every
  // access is reported as an error rather than returning wrong data.
  localparam logic LAT_OK = (RAM_LAT == 1);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [31:0]       ld_data;
  logic [31:0]       st_word;
  logic              legal_in;

  assign legal_in = LAT_OK && access_legal(we_i, funct3_i, addr_i[1:0]);

  lsu_lane_align u_align (
    .rd_word_i  (ram_q_i),
    .old_word_i (ram_q_i),
    .wdata_i    (wdata_q),
    .addr_lo_i  (addr_q[1:0]),
    .funct3_i   (funct3_q),
    .ld_data_o  (ld_data),
    .st_word_o  (st_word)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      funct3_q <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    funct3_d = funct3_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          addr_d   = addr_i;
          funct3_d = funct3_i;
          we_d     = we_i;
          wdata_d  = wdata_i;
          if (!legal_in) begin
            state_d = ST_ERR;
          end else if (is_word_store(we_i, funct3_i)) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD: state_d = ST_RWAIT;
      ST_RWAIT: begin
        // wdata_q doubles as the RAM write register, so the merged word
        // replaces the raw store data before the write cycle.
        if (we_q) begin
          wdata_d = st_word;
          state_d = ST_WR;
        end else begin
          rdata_d = ld_data;
          state_d = ST_DONE;
        end
      end
      ST_WR:   state_d = ST_DONE;
      ST_ERR:  state_d = ST_IDLE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_DONE) || (state_q == ST_ERR);
  assign err_o       = (state_q == ST_ERR);
  assign rdata_o     = rdata_q;
  assign ram_addr_o  = addr_q[ADDR_W-1:2];
  assign ram_wdata_o = wdata_q;
  assign ram_rden_o  = (state_q == ST_RD);
  assign ram_wren_o  = (state_q == ST_WR);

endmodule

// File: tb/tb_lsu_ram_port.sv
// Scoreboard bench for lsu_ram_port with a behavioural 1-cycle-latency RAM.
module tb_lsu_ram_port;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  f3 = 3'b000;
  logic [7:0]  addr = 8'h00;
  logic [31:0] wdata = 32'h0;
  logic        busy, done, err;
  logic [31:0] rdata;
  logic [5:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_rden, ram_wren;
  logic [31:0] ram_q = 32'h0;
  logic [31:0] mem [64];

  int cyc = 0;
  int chk_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    logic        err;
    logic        chk_rd;
    logic [31:0] rdata;
    int          t0;
    int          done_cyc;
    int          n_rd;
    int          n_wr;
    int          wr_cyc;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [31:0] last_rdata = 32'h0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          wr_cyc_seen = 0;
  logic [5:0]  wr_addr_seen = 6'h0;
  logic [31:0] wr_data_seen = 32'h0;

  lsu_ram_port #(.ADDR_W(8), .RAM_LAT(1)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_i       (req),
    .we_i        (we),
    .funct3_i    (f3),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .rdata_o     (rdata),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_rden_o  (ram_rden),
    .ram_wren_o  (ram_wren),
    .ram_q_i     (ram_q)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (ram_rden) ram_q <= mem[ram_addr];
    if (ram_wren) mem[ram_addr] <= ram_wdata;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    chk_cnt++;
    if (got !== want) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on done.
  always @(negedge clk) begin
    if (!rst_n) begin
      rd_cnt = 0;
      wr_cnt = 0;
    end else begin
      if (ram_rden && ram_wren) check_eq("rd_wr_excl", 32'(ram_rden & ram_wren), 32'h0);
      if (ram_rden) rd_cnt++;
      if (ram_wren) begin
        wr_cnt++;
        wr_cyc_seen  = cyc;
        wr_addr_seen = ram_addr;
        wr_data_seen = ram_wdata;
      end
      if (sb_q.size() > 0) begin
        mon_e = sb_q[0];
        if (cyc > mon_e.t0 && cyc <= mon_e.done_cyc) check_eq("busy", 32'(busy), 32'h1);
      end
      if (done) begin
        if (sb_q.size() == 0) begin
          check_eq("spurious_done", 32'(done), 32'h0);
        end else begin
          mon_e = sb_q.pop_front();
          $display("txn t0=%0d done=%0d err=%0b rdata=%08h wren=%0d rden=%0d",
                   mon_e.t0, cyc, err, rdata, wr_cnt, rd_cnt);
          check_eq("done_cyc", cyc, mon_e.done_cyc);
          check_eq("err", 32'(err), 32'(mon_e.err));
          if (mon_e.chk_rd) check_eq("rdata", rdata, mon_e.rdata);
          check_eq("n_rden", rd_cnt, mon_e.n_rd);
          check_eq("n_wren", wr_cnt, mon_e.n_wr);
          if (mon_e.n_wr > 0) begin
            check_eq("wren_cyc", wr_cyc_seen, mon_e.wr_cyc);
            check_eq("wr_addr", 32'(wr_addr_seen), 32'(mon_e.wr_addr));
            check_eq("wr_data", wr_data_seen, mon_e.wr_data);
          end
        end
        rd_cnt = 0;
        wr_cnt = 0;
      end
    end
  end

  task automatic push_exp(input logic w, input logic [2:0] fn, input logic [7:0] a,
                          input logic e_err, input logic [31:0] val);
    exp_t e;
    int   lat;
    e.t0 = cyc;
    e.err = e_err;
    e.chk_rd = e_err || !w;
    e.rdata = e_err ? last_rdata : val;
    e.wr_data = val;
    e.wr_addr = a[7:2];
    if (e_err) begin
      lat = 1; e.n_rd = 0; e.n_wr = 0;
    end else if (!w) begin
      lat = 3; e.n_rd = 1; e.n_wr = 0;
      last_rdata = val;
    end else if (fn == 3'b010) begin
      lat = 2; e.n_rd = 0; e.n_wr = 1;
    end else begin
      lat = 4; e.n_rd = 1; e.n_wr = 1;
    end
    e.done_cyc = cyc + lat;
    e.wr_cyc = e.done_cyc - 1;
    sb_q.push_back(e);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 16; i++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk); #1;
    end
    if (sb_q.size() != 0) begin
      check_eq("timeout", sb_q.size(), 0);
      sb_q.delete();
    end
  endtask

  // val: expected rdata for loads, expected written RAM word for stores.
  task automatic issue(input logic w, input logic [2:0] fn, input logic [7:0] a,
                       input logic [31:0] wd, input logic e_err, input logic [31:0] val);
    @(negedge clk); #1;
    check_eq("busy_idle", 32'(busy), 32'h0);
    req = 1'b1; we = w; f3 = fn; addr = a; wdata = wd;
    push_exp(w, fn, a, e_err, val);
    @(negedge clk); #1;
    req = 1'b0; we = ~w; f3 = 3'b111; addr = 8'hFC; wdata = 32'h5A5A5A5A;
    wait_idle();
  endtask

  task automatic check_zero(input string pfx);
    check_eq({pfx, "_busy"}, 32'(busy), 32'h0);
    check_eq({pfx, "_done"}, 32'(done), 32'h0);
    check_eq({pfx, "_err"}, 32'(err), 32'h0);
    check_eq({pfx, "_rdata"}, rdata, 32'h0);
    check_eq({pfx, "_ram_addr"}, 32'(ram_addr), 32'h0);
    check_eq({pfx, "_ram_wdata"}, ram_wdata, 32'h0);
    check_eq({pfx, "_rden"}, 32'(ram_rden), 32'h0);
    check_eq({pfx, "_wren"}, 32'(ram_wren), 32'h0);
  endtask

  initial begin
    #12;
    check_zero("reset");
    @(negedge clk); rst_n = 1'b1;

    // Word round trip
    issue(1'b1, 3'b010, 8'h10, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF);
    issue(1'b0, 3'b010, 8'h10, 32'h0, 1'b0, 32'hDEADBEEF);

    // Sign/zero extension
    issue(1'b1, 3'b010, 8'h20, 32'h80FF7F01, 1'b0, 32'h80FF7F01);
    issue(1'b0, 3'b000, 8'h22, 32'h0, 1'b0, 32'hFFFFFFFF);
    issue(1'b0, 3'b100, 8'h23, 32'h0, 1'b0, 32'h00000080);
    issue(1'b0, 3'b001, 8'h22, 32'h0, 1'b0, 32'hFFFF80FF);
    issue(1'b0, 3'b101, 8'h20, 32'h0, 1'b0, 32'h00007F01);
    issue(1'b0, 3'b000, 8'h20, 32'h0, 1'b0, 32'h00000001);

    // Sub-word read-modify-write
    issue(1'b1, 3'b010, 8'h30, 32'h11223344, 1'b0, 32'h11223344);
    issue(1'b1, 3'b000, 8'h31, 32'h000000AB, 1'b0, 32'h1122AB44);
    issue(1'b1, 3'b001, 8'h32, 32'h0000CAFE, 1'b0, 32'hCAFEAB44);
    issue(1'b0, 3'b010, 8'h30, 32'h0, 1'b0, 32'hCAFEAB44);
    check_eq("mem_0x10", mem[4], 32'hDEADBEEF);
    check_eq("mem_0x30", mem[12], 32'hCAFEAB44);

    // Errors: rdata must stay at the last load result
    issue(1'b0, 3'b010, 8'h05, 32'h0, 1'b1, 32'h0);
    issue(1'b1, 3'b001, 8'h07, 32'h12345678, 1'b1, 32'h0);
    issue(1'b0, 3'b011, 8'h10, 32'h0, 1'b1, 32'h0);
    issue(1'b1, 3'b100, 8'h10, 32'h0, 1'b1, 32'h0);
    check_eq("mem_0x10_after_err", mem[4], 32'hDEADBEEF);

    // Handshake: req held high, address changing while busy
    @(negedge clk); #1;
    check_eq("hs_busy0", 32'(busy), 32'h0);
    req = 1'b1; we = 1'b0; f3 = 3'b010; addr = 8'h10;
    push_exp(1'b0, 3'b010, 8'h10, 1'b0, 32'hDEADBEEF);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); #1;
      case (k)
        1: addr = 8'h20;
        2: addr = 8'h24;
        3: addr = 8'h30;
        4: begin
          check_eq("hs_busy_b2b", 32'(busy), 32'h0);
          push_exp(1'b0, 3'b010, 8'h30, 1'b0, 32'hCAFEAB44);
        end
        default: begin req = 1'b0; addr = 8'hFC; end
      endcase
    end
    wait_idle();

    // Reset during the RWAIT cycle of an SB
    issue(1'b1, 3'b010, 8'h40, 32'h55667788, 1'b0, 32'h55667788);
    @(negedge clk); #1;
    req = 1'b1; we = 1'b1; f3 = 3'b000; addr = 8'h41; wdata = 32'h00000099;
    @(negedge clk); #1;
    req = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    last_rdata = 32'h0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check_eq("rst_no_wren", wr_cnt, 0);
    check_eq("rst_rdata", rdata, 32'h0);
    check_eq("rst_mem_0x40", mem[16], 32'h55667788);
    issue(1'b0, 3'b010, 8'h40, 32'h0, 1'b0, 32'h55667788);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/lsu_ram_port.md
Name: lsu_ram_port

Overview:
- Load/store unit between the ALU result (effective address) and register-file rd2 (store data) on one side, and the single-port 32-bit word RAM on the other.
- Implements RV32I LB/LH/LW/LBU/LHU and SB/SH/SW on a word-only-write RAM with 1-cycle registered read latency.
- Sub-word stores use a read-modify-write sequence.
- Provides a busy/done handshake so the core's PC update can stall until the access completes.

Parameters:
- ADDR_W, 8, byte-address width; RAM word address is addr[ADDR_W-1:2].
- RAM_LAT, 1, RAM read latency in cycles; only the value 1 is supported.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  1  access request; sampled only when busy=0.
- we  in  1  1=store, 0=load; sampled with req.
- funct3  in  3  instr[14:12]; selects width and sign.
- addr  in  ADDR_W  byte address (ALU Y).
- wdata  in  32  store data (rd2).
- busy  out  1  1 while not IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; misaligned or illegal funct3.
- rdata  out  32  load result, extended; valid with done, held until next done.
- ram_addr  out  ADDR_W-2  RAM word address.
- ram_wdata  out  32  RAM write data.
- ram_rden  out  1  RAM read enable.
- ram_wren  out  1  RAM write enable.
- ram_q  in  32  RAM read data, valid the cycle after the ram_rden cycle.

Behaviour:
- Clock/reset:
  - Single clock domain: clk.
  - Reset rst_n is asynchronous, active-low.
  - Reset forces state=IDLE, and busy, done, err, ram_rden, ram_wren, ram_addr, ram_wdata and rdata to 0.
  - Reset mid-operation aborts the access with no write issued after assertion and no done pulse.
- Capture: in IDLE with req=1, addr, funct3, we and wdata are registered; later changes on these inputs are ignored. req while busy=1 is ignored, not queued.
- Legality:
  - Loads: funct3 000/001/010/100/101 legal.
  - Stores: funct3 000/001/010 legal.
  - Halfword access needs addr[0]=0; word access needs addr[1:0]=00.
  - An illegal access goes IDLE->ERR. ERR makes no RAM access and pulses done=1, err=1, with rdata unchanged.
- States: IDLE, RD, RWAIT, WR, ERR, DONE.
  - IDLE -> RD on a load or sub-word store.
  - IDLE -> WR on SW.
  - RD asserts ram_rden=1, then -> RWAIT.
  - RWAIT samples ram_q.
    - Load: extract and extend into rdata, then -> DONE.
    - SB/SH: merge into ram_wdata, then -> WR.
  - WR asserts ram_wren=1 for exactly one cycle, then -> DONE.
  - DONE and ERR pulse done for one cycle, then -> IDLE.
- Cycle counts (req in cycle 0):
  - Load: done in cycle 3.
  - SW: ram_wren in cycle 1, done in cycle 2.
  - SB/SH: ram_rden in cycle 1, ram_wren in cycle 3, done in cycle 4.
  - Error: done in cycle 1.
- busy is 1 from cycle 1 through the done cycle inclusive.
- ram_rden and ram_wren are never asserted together.
- Byte lanes are little-endian: byte k = bits [8k+7:8k], k=addr[1:0]; halfword h = bits [16h+15:16h], h=addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - SB/SH replace only the addressed lane; the other bytes come from the RMW read.
- ram_addr holds the captured word address from RD through WR.
- Address wrap is not applicable: ADDR_W bits cover the whole RAM.
- A new req may be accepted in the cycle after done (back-to-back throughput).

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - State encoding.
  - Constant RAM_LAT.
- Natural sub-module: lsu_lane_align, purely combinational. It provides:
  - extract plus sign/zero extend: word, addr[1:0], funct3 -> 32 bits;
  - merge: old word, wdata, addr[1:0], funct3 -> new word.
- The FSM stays in lsu_ram_port.

Test Plan:
- Word round trip: SW addr=0x10 wdata=0xDEADBEEF, then LW addr=0x10.
  - SW: ram_wren in cycle 1 with ram_addr=0x04; done in cycle 2.
  - LW: done in cycle 3; rdata=0xDEADBEEF, err=0.
- Sign/zero extension: RAM word 0x80FF7F01 at 0x20.
  - LB 0x22 -> 0xFFFFFFFF; LBU 0x23 -> 0x00000080.
  - LH 0x22 -> 0xFFFF80FF; LHU 0x20 -> 0x00007F01; LB 0x20 -> 0x00000001.
- Sub-word RMW: word 0x11223344 at 0x30.
  - SB 0x31 wdata=0xAB -> written word 0x1122AB44, ram_wren only in cycle 3, done in cycle 4.
  - SH 0x32 wdata=0xCAFE -> 0xCAFEAB44.
- Errors:
  - LW 0x05 -> done+err in cycle 1, no ram_rden/ram_wren, rdata unchanged.
  - SH 0x07 -> same error response.
  - Load funct3=011 -> same error response.
- Handshake: hold req=1 continuously with changing addr during a load.
  - Only the cycle-0 address is used.
  - The next request is accepted the cycle after done.
  - busy is high in cycles 1-3.
- Reset mid-op: assert rst_n=0 during RWAIT of an SB.
  - Outputs go to 0 immediately; no ram_wren; no done.
  - The RAM word is unchanged after release.
